// File: rtl/pll_rst_seq_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  localparam logic [7:0] LOSS_COUNT_MAX = 8'd255;

  // Counter width able to hold 0 .. cycles-1 (at least one bit).
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == LOSS_COUNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Metastability filter chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, lock qualification and system reset release, and
// recovers from lock loss or external reset requests.
module pll_reset_sequencer
  import pll_rst_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int RELEASE_CYCLES      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       ext_reset_req,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic [7:0] lock_loss_count,
  output logic       timeout_flag
);

  localparam int RST_W  = cnt_width(PLL_RST_CYCLES);
  localparam int TO_W   = cnt_width(LOCK_TIMEOUT_CYCLES);
  localparam int STAB_W = cnt_width(LOCK_STABLE_CYCLES);
  localparam int REL_W  = cnt_width(RELEASE_CYCLES);

  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(RELEASE_CYCLES - 1);

  logic locked_s;
  logic ext_s;

  state_e            state_q,        state_d;
  logic [RST_W-1:0]  rst_cnt_q,      rst_cnt_d;
  logic [TO_W-1:0]   to_cnt_q,       to_cnt_d;
  logic [STAB_W-1:0] stab_cnt_q,     stab_cnt_d;
  logic [REL_W-1:0]  rel_cnt_q,      rel_cnt_d;
  logic [7:0]        loss_cnt_q,     loss_cnt_d;
  logic              timeout_flag_q, timeout_flag_d;
  logic              pll_rst_q,      pll_rst_d;
  logic              sys_reset_q,    sys_reset_d;
  logic              ready_q,        ready_d;

  sync_2ff u_sync_locked (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  sync_2ff u_sync_ext (
    .clk (clk),
    .rst (rst),
    .d   (ext_reset_req),
    .q   (ext_s)
  );

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_PLL_RESET;
      rst_cnt_q      <= {RST_W{1'b0}};
      to_cnt_q       <= {TO_W{1'b0}};
      stab_cnt_q     <= {STAB_W{1'b0}};
      rel_cnt_q      <= {REL_W{1'b0}};
      loss_cnt_q     <= 8'd0;
      timeout_flag_q <= 1'b0;
      pll_rst_q      <= 1'b1;
      sys_reset_q    <= 1'b1;
      ready_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      rst_cnt_q      <= rst_cnt_d;
      to_cnt_q       <= to_cnt_d;
      stab_cnt_q     <= stab_cnt_d;
      rel_cnt_q      <= rel_cnt_d;
      loss_cnt_q     <= loss_cnt_d;
      timeout_flag_q <= timeout_flag_d;
      pll_rst_q      <= pll_rst_d;
      sys_reset_q    <= sys_reset_d;
      ready_q        <= ready_d;
    end
  end

  // Next-state logic; every entry into a timed state clears that state's counter.
  always_comb begin
    state_d        = state_q;
    rst_cnt_d      = rst_cnt_q;
    to_cnt_d       = to_cnt_q;
    stab_cnt_d     = stab_cnt_q;
    rel_cnt_d      = rel_cnt_q;
    loss_cnt_d     = loss_cnt_q;
    timeout_flag_d = timeout_flag_q;
    case (state_q)
      ST_PLL_RESET: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d  = ST_WAIT_LOCK;
          to_cnt_d = {TO_W{1'b0}};
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d    = ST_STABLE;
          stab_cnt_d = {STAB_W{1'b0}};
        end else if (to_cnt_q == TO_LAST) begin
          state_d        = ST_PLL_RESET;
          rst_cnt_d      = {RST_W{1'b0}};
          timeout_flag_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_STABLE: begin
        // Lock dropping before release is not counted as a loss.
        if (!locked_s) begin
          state_d  = ST_WAIT_LOCK;
          to_cnt_d = {TO_W{1'b0}};
        end else if (ext_s) begin
          stab_cnt_d = {STAB_W{1'b0}};
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d   = ST_RELEASE;
          rel_cnt_d = {REL_W{1'b0}};
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!locked_s) begin
          state_d    = ST_PLL_RESET;
          rst_cnt_d  = {RST_W{1'b0}};
          loss_cnt_d = sat_inc8(loss_cnt_q);
        end else if (ext_s) begin
          state_d    = ST_STABLE;
          stab_cnt_d = {STAB_W{1'b0}};
        end else if (rel_cnt_q == REL_LAST) begin
          state_d = ST_RUN;
        end else begin
          rel_cnt_d = rel_cnt_q + REL_W'(1);
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d    = ST_PLL_RESET;
          rst_cnt_d  = {RST_W{1'b0}};
          loss_cnt_d = sat_inc8(loss_cnt_q);
        end else if (ext_s) begin
          state_d    = ST_STABLE;
          stab_cnt_d = {STAB_W{1'b0}};
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d   = ST_PLL_RESET;
        rst_cnt_d = {RST_W{1'b0}};
      end
    endcase
  end

  // Outputs decoded from the next state so they change on the transition edge.
  always_comb begin
    pll_rst_d   = 1'b1;
    sys_reset_d = 1'b1;
    ready_d     = 1'b0;
    case (state_d)
      ST_PLL_RESET: begin
        pll_rst_d   = 1'b1;
        sys_reset_d = 1'b1;
        ready_d     = 1'b0;
      end
      ST_WAIT_LOCK, ST_STABLE: begin
        pll_rst_d   = 1'b0;
        sys_reset_d = 1'b1;
        ready_d     = 1'b0;
      end
      ST_RELEASE: begin
        pll_rst_d   = 1'b0;
        sys_reset_d = 1'b0;
        ready_d     = 1'b0;
      end
      ST_RUN: begin
        pll_rst_d   = 1'b0;
        sys_reset_d = 1'b0;
        ready_d     = 1'b1;
      end
      default: begin
        pll_rst_d   = 1'b1;
        sys_reset_d = 1'b1;
        ready_d     = 1'b0;
      end
    endcase
  end

  assign pll_rst         = pll_rst_q;
  assign sys_reset       = sys_reset_q;
  assign ready           = ready_q;
  assign lock_loss_count = loss_cnt_q;
  assign timeout_flag    = timeout_flag_q;

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: clk cycles pll_rst is held high per PLL reset pulse.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before release.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: maximum WAIT_LOCK cycles before the PLL is re-reset.
REQ-004 SHALL have parameter RELEASE_CYCLES, default 8: cycles between sys_reset deassertion and ready assertion.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, the free-running 50 MHz board reference, never a PLL output.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port pll_locked, input, 1 bit: PLL lock indication, asynchronous to clk.
REQ-008 SHALL have port ext_reset_req, input, 1 bit: asynchronous active-high external reset request (button/host).
REQ-009 SHALL have port pll_rst, output, 1 bit: active-high reset driven to the PLL rst input.
REQ-010 SHALL have port sys_reset, output, 1 bit: active-high system reset for downstream logic.
REQ-011 SHALL have port ready, output, 1 bit: high when the system clock is locked, stable and out of reset.
REQ-012 SHALL have port lock_loss_count, output, 8 bits: saturating count of lock losses after release.
REQ-013 SHALL have port timeout_flag, output, 1 bit: sticky, set on any WAIT_LOCK timeout.

Function
REQ-014 SHALL pass pll_locked and ext_reset_req through two-flop synchronizers; FSM uses only the synchronized versions (locked_s, ext_s).
REQ-015 SHALL register all outputs; no combinational path from any input to any output.
REQ-016 SHALL implement states PLL_RESET, WAIT_LOCK, STABLE, RELEASE, RUN.
REQ-017 PLL_RESET: pll_rst=1, sys_reset=1, ready=0; after exactly PLL_RST_CYCLES cycles -> WAIT_LOCK, pll_rst=0 on that edge.
REQ-018 WAIT_LOCK: locked_s=1 -> STABLE with stable counter cleared; else after LOCK_TIMEOUT_CYCLES cycles -> PLL_RESET and set timeout_flag.
REQ-019 STABLE: locked_s=0 -> WAIT_LOCK with timeout counter cleared, no lock_loss increment; after LOCK_STABLE_CYCLES consecutive locked cycles -> RELEASE, sys_reset=0 on that edge.
REQ-020 Latency: sys_reset SHALL fall exactly LOCK_STABLE_CYCLES+3 clk edges after a clean pll_locked rise observed in WAIT_LOCK.
REQ-021 RELEASE: sys_reset=0, ready=0 for RELEASE_CYCLES cycles, then -> RUN with ready=1 on that edge.
REQ-022 RELEASE/RUN with locked_s=0: next edge sys_reset=1, ready=0, lock_loss_count+1 (saturates at 255), -> PLL_RESET.
REQ-023 STABLE/RELEASE/RUN with ext_s=1: next edge sys_reset=1, ready=0, -> STABLE with counter cleared; PLL not reset; remains in STABLE while ext_s=1.
REQ-024 Simultaneous lock loss and ext_s in RELEASE/RUN: lock loss SHALL take priority (REQ-022).
REQ-025 ext_s in PLL_RESET/WAIT_LOCK SHALL be ignored.
REQ-026 All cycle counters SHALL be sized from their parameters and never wrap.

Reset
REQ-027 rst=1 SHALL asynchronously force state=PLL_RESET, pll_rst=1, sys_reset=1, ready=0, lock_loss_count=0, timeout_flag=0, all counters and synchronizer flops 0.
REQ-028 rst deassertion SHALL start a full PLL_RST_CYCLES pulse; rst mid-operation aborts any state identically.

Structure
REQ-029 Shared package pll_rst_seq_pkg SHALL hold the state enum and LOSS_COUNT_MAX=255.
REQ-030 Synchronizers SHALL be instances of sub-module sync_2ff (1-bit, async reset to 0).

Verification (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, RELEASE_CYCLES=4)
REQ-031 Release rst, raise pll_locked at edge 10 -> pll_rst high edges 1-4, sys_reset falls edge 21, ready rises edge 25.
REQ-032 pll_locked never rises -> timeout_flag set and pll_rst re-pulses 4 cycles after 32 WAIT_LOCK cycles; repeats.
REQ-033 In RUN drop pll_locked 1 cycle -> sys_reset=1 and ready=0 at edge 3 after drop, lock_loss_count=1, pll_rst pulses.
REQ-034 In RUN pulse ext_reset_req 2 cycles -> sys_reset high, pll_rst stays 0, ready returns 8+4+ sync cycles later.
REQ-035 Glitch pll_locked low for 3 cycles during STABLE -> return to WAIT_LOCK, lock_loss_count unchanged, full re-count.
REQ-036 Force 300 lock losses -> lock_loss_count holds 255; assert rst mid-RELEASE -> all outputs at reset values immediately.
